// File: rtl/vram_ahb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_ahb_arbiter
// Description : Single-port video-RAM arbiter. It is an AHB-Lite slave on the
//               CPU side and serves a VGA scan-out pixel fetcher on the video
//               side. Both share one synchronous single-port RAM (one-cycle
//               read latency). Video fetches always take the port when they
//               request it. CPU transfers wait in the WR/RD states with
//               HREADYOUT low until the port is free.
// Build macro : VRAM_ARB_STARVE_EN
//               When defined, a starvation guard lets the CPU through on the
//               next contended cycle once it has lost MAX_WAIT cycles to video
//               while waiting. When undefined, video has strict priority.
// Parameters  : ADDR_W    VRAM word-address width (depth 2^ADDR_W x 32)
//               MAX_WAIT  CPU cycles lost to video before the CPU is forced
// Ports       : HCLK, SI_Reset (async, active-high)
//               AHB-Lite slave : HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
//                                HREADY -> HREADYOUT, HRDATA, HRESP
//               Video fetcher  : vid_req, vid_addr -> vid_gnt, vid_rvalid,
//                                vid_rdata
//               RAM port       : ram_en, ram_we, ram_addr, ram_wdata <- ram_rdata
// Revision    : 1.0  initial release
// ============================================================================
module vram_ahb_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int MAX_WAIT = 4
) (
  input  logic              HCLK,
  input  logic              SI_Reset,
  // AHB-Lite slave
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic [31:0]       HRDATA,
  output logic              HRESP,
  // Video fetcher
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [31:0]       vid_rdata,
  // Single-port RAM
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_RD    = 3'd2,
    S_RDATA = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  // Captured address-phase information
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [2:0]        r_size;
  logic [1:0]        r_lane;

  logic [31:0]       r_hrdata;
  logic              r_vid_rvalid;

  logic              w_accept;
  logic              w_capture;
  logic              w_cpu_pending;
  logic              w_vid_win;
  logic              w_cpu_issue;
  logic [3:0]        w_byte_en;
  logic              w_unused_bits;

  // A new address phase is only accepted when no transfer is outstanding,
  // i.e. in the two states that drive HREADYOUT high.
  assign w_accept      = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_capture     = w_accept && HSEL && HTRANS[1] && HREADY;
  assign w_cpu_pending = (r_state == S_WR) || (r_state == S_RD);

  // --------------------------------------------------------------------------
  // Port arbitration
  // --------------------------------------------------------------------------
`ifdef VRAM_ARB_STARVE_EN
  // Extra bit of headroom keeps the width non-zero for MAX_WAIT = 0.
  localparam int c_CNT_W = $clog2(MAX_WAIT + 2);

  logic [c_CNT_W-1:0] r_starve_cnt;
  logic               w_force_cpu;

  // Once the pending CPU access has lost MAX_WAIT cycles, video is held off
  // for exactly one cycle so the CPU can go through.
  assign w_force_cpu = w_cpu_pending && (r_starve_cnt >= c_CNT_W'(MAX_WAIT));
  assign w_vid_win   = vid_req && !w_force_cpu && !SI_Reset;

  always_ff @(posedge HCLK or posedge SI_Reset) begin
    if (SI_Reset) begin
      r_starve_cnt <= '0;
    end else if (w_cpu_issue) begin
      r_starve_cnt <= '0;
    end else if (w_cpu_pending && w_vid_win &&
                 (r_starve_cnt < c_CNT_W'(MAX_WAIT))) begin
      r_starve_cnt <= r_starve_cnt + c_CNT_W'(1);
    end
  end
`else
  // Strict video priority: the CPU waits for as long as vid_req is held.
  assign w_vid_win = vid_req && !SI_Reset;
`endif

  // The CPU gets the port only in cycles video does not use it. The reset
  // term keeps the RAM strobe quiet for the whole time reset is asserted.
  assign w_cpu_issue = w_cpu_pending && !w_vid_win && !SI_Reset;

  // --------------------------------------------------------------------------
  // Transfer FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge HCLK or posedge SI_Reset) begin
    if (SI_Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_capture) begin
          w_state_nxt = HWRITE ? S_WR : S_RD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WR: begin
        if (w_cpu_issue) begin
          w_state_nxt = S_DONE;
        end
      end
      S_RD: begin
        if (w_cpu_issue) begin
          w_state_nxt = S_RDATA;
        end
      end
      S_RDATA: begin
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Address-phase capture
  // --------------------------------------------------------------------------
  always_ff @(posedge HCLK or posedge SI_Reset) begin
    if (SI_Reset) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= 3'd0;
      r_lane  <= 2'd0;
    end else if (w_capture) begin
      r_addr  <= HADDR[ADDR_W+1:2];
      r_write <= HWRITE;
      r_size  <= HSIZE;
      r_lane  <= HADDR[1:0];
    end
  end

  // Read data is taken from the RAM in its output cycle and held until the
  // next read completes, so it stays stable throughout DONE.
  always_ff @(posedge HCLK or posedge SI_Reset) begin
    if (SI_Reset) begin
      r_hrdata <= 32'd0;
    end else if (r_state == S_RDATA) begin
      r_hrdata <= ram_rdata;
    end
  end

  always_ff @(posedge HCLK or posedge SI_Reset) begin
    if (SI_Reset) begin
      r_vid_rvalid <= 1'b0;
    end else begin
      r_vid_rvalid <= w_vid_win;
    end
  end

  // --------------------------------------------------------------------------
  // Little-endian byte lanes. Sizes above a word are treated as a word.
  // --------------------------------------------------------------------------
  always_comb begin
    w_byte_en = 4'b1111;
    case (r_size)
      3'd0:    w_byte_en = 4'b0001 << r_lane;
      3'd1:    w_byte_en = r_lane[1] ? 4'b1100 : 4'b0011;
      default: w_byte_en = 4'b1111;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ram_en    = w_vid_win || w_cpu_issue;
  assign ram_addr  = w_vid_win ? vid_addr : r_addr;
  assign ram_we    = (w_cpu_issue && r_write) ? w_byte_en : 4'b0000;
  // HWDATA stays valid while the data phase is stretched, so it can be
  // passed straight to the RAM in whatever cycle the write finally issues.
  assign ram_wdata = HWDATA;

  assign HREADYOUT  = w_accept;
  assign HRDATA     = r_hrdata;
  assign HRESP      = 1'b0;

  assign vid_gnt    = w_vid_win;
  assign vid_rvalid = r_vid_rvalid;
  assign vid_rdata  = ram_rdata;

  // Address bits above the VRAM window, HTRANS[0] (SEQ vs NONSEQ) and the
  // guard depth in a build without the guard carry no meaning here.
  assign w_unused_bits = ^{HADDR[31:ADDR_W+2], HTRANS[0], (MAX_WAIT > 0)};

endmodule
`default_nettype wire

// File: tb/tb_vram_ahb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_ahb_arbiter
// Description : Directed self-checking bench for vram_ahb_arbiter with a
//               behavioural single-port RAM (one-cycle read latency, byte
//               enables). HREADY is looped back from HREADYOUT as a
//               single-slave bus would do. Respects VRAM_ARB_STARVE_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vram_ahb_arbiter;

  localparam int c_ADDR_W = 13;

  logic                HCLK;
  logic                SI_Reset;
  logic                HSEL;
  logic [31:0]         HADDR;
  logic [1:0]          HTRANS;
  logic                HWRITE;
  logic [2:0]          HSIZE;
  logic [31:0]         HWDATA;
  logic                HREADY;
  logic                HREADYOUT;
  logic [31:0]         HRDATA;
  logic                HRESP;
  logic                vid_req;
  logic [c_ADDR_W-1:0] vid_addr;
  logic                vid_gnt;
  logic                vid_rvalid;
  logic [31:0]         vid_rdata;
  logic                ram_en;
  logic [3:0]          ram_we;
  logic [c_ADDR_W-1:0] ram_addr;
  logic [31:0]         ram_wdata;
  logic [31:0]         ram_rdata;

  int n_checks;
  int n_errors;

  logic [31:0] mem [0:(1<<c_ADDR_W)-1];

  vram_ahb_arbiter #(
    .ADDR_W   (c_ADDR_W),
    .MAX_WAIT (4)
  ) u_dut (
    .HCLK       (HCLK),
    .SI_Reset   (SI_Reset),
    .HSEL       (HSEL),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HWDATA     (HWDATA),
    .HREADY     (HREADY),
    .HREADYOUT  (HREADYOUT),
    .HRDATA     (HRDATA),
    .HRESP      (HRESP),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_gnt    (vid_gnt),
    .vid_rvalid (vid_rvalid),
    .vid_rdata  (vid_rdata),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  assign HREADY = HREADYOUT;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Behavioural synchronous RAM: read-before-write, one-cycle latency.
  always @(posedge HCLK) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Step into the next cycle; inputs driven here, outputs sampled #1 later.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w,
                            input logic [2:0] sz);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HADDR  = a;
    HWRITE = w;
    HSIZE  = sz;
  endtask

  task automatic bus_idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
  endtask

  // Write with the port free: issue in T1, HREADYOUT high in T2.
  task automatic do_write(input string tag, input logic [31:0] a,
                          input logic [2:0] sz, input logic [31:0] d,
                          input logic [3:0] exp_we,
                          input logic [c_ADDR_W-1:0] exp_addr);
    tick();
    addr_phase(a, 1'b1, sz);
    tick();
    bus_idle();
    HWDATA = d;
    #1;
    check({tag, "_en"},   {31'd0, ram_en}, 32'd1);
    check({tag, "_we"},   {28'd0, ram_we}, {28'd0, exp_we});
    check({tag, "_addr"}, {19'd0, ram_addr}, {19'd0, exp_addr});
    check({tag, "_wait"}, {31'd0, HREADYOUT}, 32'd0);
    tick();
    #1;
    check({tag, "_rdy"},  {31'd0, HREADYOUT}, 32'd1);
  endtask

  // Read with the port free: issue T1, RAM output T2, HRDATA valid in T3.
  task automatic do_read(input string tag, input logic [31:0] a,
                         input logic [c_ADDR_W-1:0] exp_addr,
                         input logic [31:0] exp_data);
    tick();
    addr_phase(a, 1'b0, 3'd2);
    tick();
    bus_idle();
    #1;
    check({tag, "_en"},   {31'd0, ram_en}, 32'd1);
    check({tag, "_we"},   {28'd0, ram_we}, 32'd0);
    check({tag, "_addr"}, {19'd0, ram_addr}, {19'd0, exp_addr});
    tick();
    #1;
    check({tag, "_wait2"}, {31'd0, HREADYOUT}, 32'd0);
    tick();
    #1;
    check({tag, "_rdy"},  {31'd0, HREADYOUT}, 32'd1);
    check({tag, "_data"}, HRDATA, exp_data);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < (1 << c_ADDR_W); i++) mem[i] = 32'd0;
    mem[256]  = 32'h1234_5678;
    ram_rdata = 32'd0;

    // Reset with vid_req held high: the port must stay quiet.
    SI_Reset = 1'b1;
    HSEL = 1'b0; HADDR = 32'd0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'd0; HWDATA = 32'd0;
    vid_req = 1'b1; vid_addr = 13'h100;
    tick();
    tick();
    #1;
    check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    check("rst_hrdata",    HRDATA, 32'd0);
    check("rst_hresp",     {31'd0, HRESP}, 32'd0);
    check("rst_vid_gnt",   {31'd0, vid_gnt}, 32'd0);
    check("rst_vid_rvalid",{31'd0, vid_rvalid}, 32'd0);
    check("rst_ram_en",    {31'd0, ram_en}, 32'd0);
    check("rst_ram_we",    {28'd0, ram_we}, 32'd0);
    tick();
    SI_Reset = 1'b0;
    vid_req  = 1'b0;

    // Word, byte and half-word writes, then read-backs.
    do_write("wr_word", 32'h10, 3'd2, 32'hDEAD_BEEF, 4'b1111, 13'd4);
    check("wr_word_wdata", mem[4], 32'hDEAD_BEEF);
    do_write("wr_byte", 32'h13, 3'd0, 32'hAA00_0000, 4'b1000, 13'd4);
    do_write("wr_half", 32'h22, 3'd1, 32'h5555_0000, 4'b1100, 13'd8);
    do_write("wr_hsz7", 32'h40, 3'd7, 32'h0BAD_F00D, 4'b1111, 13'd16);
    do_read("rd_mix",  32'h10, 13'd4,  32'hAAAD_BEEF);
    do_read("rd_half", 32'h20, 13'd8,  32'h5555_0000);

    // Read while video holds the port for three cycles.
    tick();
    addr_phase(32'h10, 1'b0, 3'd2);
    tick();                                   // T1
    bus_idle();
    vid_req = 1'b1; vid_addr = 13'h100;
    #1;
    check("vid1_gnt",   {31'd0, vid_gnt}, 32'd1);
    check("vid1_addr",  {19'd0, ram_addr}, 32'h100);
    check("vid1_we",    {28'd0, ram_we}, 32'd0);
    tick();                                   // T2
    #1;
    check("vid2_gnt",    {31'd0, vid_gnt}, 32'd1);
    check("vid2_rvalid", {31'd0, vid_rvalid}, 32'd1);
    check("vid2_rdata",  vid_rdata, 32'h1234_5678);
    tick();                                   // T3
    #1;
    check("vid3_gnt",   {31'd0, vid_gnt}, 32'd1);
    check("vid3_wait",  {31'd0, HREADYOUT}, 32'd0);
    tick();                                   // T4: CPU gets the port
    vid_req = 1'b0;
    #1;
    check("vid4_gnt",    {31'd0, vid_gnt}, 32'd0);
    check("vid4_cpu_en", {31'd0, ram_en}, 32'd1);
    check("vid4_addr",   {19'd0, ram_addr}, 32'd4);
    check("vid4_rvalid", {31'd0, vid_rvalid}, 32'd1);
    tick();                                   // T5
    #1;
    check("vid5_rvalid", {31'd0, vid_rvalid}, 32'd0);
    check("vid5_wait",   {31'd0, HREADYOUT}, 32'd0);
    tick();                                   // T6
    #1;
    check("vid6_rdy",  {31'd0, HREADYOUT}, 32'd1);
    check("vid6_data", HRDATA, 32'hAAAD_BEEF);

    // Video held continuously against a pending read.
    tick();
    addr_phase(32'h20, 1'b0, 3'd2);
    tick();                                   // T1
    bus_idle();
    vid_req = 1'b1;
`ifdef VRAM_ARB_STARVE_EN
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stv_vid_gnt", {31'd0, vid_gnt}, 32'd1);
      check("stv_wait",    {31'd0, HREADYOUT}, 32'd0);
      tick();
    end
    #1;                                       // 5th contended cycle
    check("stv_forced_gnt", {31'd0, vid_gnt}, 32'd0);
    check("stv_forced_en",  {31'd0, ram_en}, 32'd1);
    check("stv_forced_addr",{19'd0, ram_addr}, 32'd8);
    tick();
    #1;
    check("stv_vid_back", {31'd0, vid_gnt}, 32'd1);
    tick();
    vid_req = 1'b0;
    #1;
    check("stv_rdy",  {31'd0, HREADYOUT}, 32'd1);
    check("stv_data", HRDATA, 32'h5555_0000);
`else
    for (int i = 0; i < 8; i++) begin
      #1;
      check("stv_vid_gnt", {31'd0, vid_gnt}, 32'd1);
      check("stv_wait",    {31'd0, HREADYOUT}, 32'd0);
      tick();
    end
    vid_req = 1'b0;
    #1;
    check("stv_cpu_gnt",  {31'd0, vid_gnt}, 32'd0);
    check("stv_cpu_en",   {31'd0, ram_en}, 32'd1);
    check("stv_cpu_addr", {19'd0, ram_addr}, 32'd8);
    tick();
    tick();
    #1;
    check("stv_rdy",  {31'd0, HREADYOUT}, 32'd1);
    check("stv_data", HRDATA, 32'h5555_0000);
`endif

    // Pipelined write then read on consecutive address phases.
    tick();
    addr_phase(32'h30, 1'b1, 3'd2);
    tick();                                   // T1: write data phase
    HWDATA = 32'hCAFE_F00D;
    addr_phase(32'h30, 1'b0, 3'd2);           // next address phase, stalled
    #1;
    check("pipe_wr_we",   {28'd0, ram_we}, 32'hF);
    check("pipe_wr_addr", {19'd0, ram_addr}, 32'd12);
    tick();                                   // T2: DONE, read accepted
    #1;
    check("pipe_wr_rdy", {31'd0, HREADYOUT}, 32'd1);
    tick();                                   // T3
    bus_idle();
    #1;
    check("pipe_rd_en",   {31'd0, ram_en}, 32'd1);
    check("pipe_rd_we",   {28'd0, ram_we}, 32'd0);
    check("pipe_rd_addr", {19'd0, ram_addr}, 32'd12);
    tick();
    tick();                                   // T5
    #1;
    check("pipe_rd_rdy",  {31'd0, HREADYOUT}, 32'd1);
    check("pipe_rd_data", HRDATA, 32'hCAFE_F00D);

    // Reset asserted while a read is waiting in RD.
    tick();
    addr_phase(32'h30, 1'b0, 3'd2);
    tick();
    bus_idle();
    vid_req = 1'b1;
    tick();
    SI_Reset = 1'b1;
    #1;
    check("mid_rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    check("mid_rst_hrdata",    HRDATA, 32'd0);
    check("mid_rst_vid_gnt",   {31'd0, vid_gnt}, 32'd0);
    check("mid_rst_rvalid",    {31'd0, vid_rvalid}, 32'd0);
    check("mid_rst_ram_en",    {31'd0, ram_en}, 32'd0);
    check("mid_rst_ram_we",    {28'd0, ram_we}, 32'd0);
    tick();
    SI_Reset = 1'b0;
    vid_req  = 1'b0;
    do_read("post_rst", 32'h30, 13'd12, 32'hCAFE_F00D);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vram_ahb_arbiter.md
# vram_ahb_arbiter

Single-port video-RAM arbiter between the AHB-Lite bus (CPU side) and the VGA scan-out pixel fetcher. It sits as an AHB-Lite slave behind the bus decoder, next to the other memory and I/O slaves, and drives one synchronous single-port RAM. Video fetches take priority. CPU accesses are stretched with HREADYOUT wait states, and an optional starvation guard bounds CPU latency.

## Interface
Parameters:
- ADDR_W, 13, VRAM word-address width (RAM depth 2^ADDR_W × 32 bit)
- MAX_WAIT, 4, CPU cycles lost to video before the CPU is forced through (used only with the starvation guard)

Ports:
- HCLK  in  1  sole clock
- SI_Reset  in  1  reset, asynchronous, active-high
- HSEL  in  1  slave select from the bus decoder
- HADDR  in  32  AHB address; word address = HADDR[ADDR_W+1:2]
- HTRANS  in  2  AHB transfer type; HTRANS[1]=1 means a valid transfer
- HWRITE  in  1  1 = write
- HSIZE  in  3  0 = byte, 1 = half, 2 = word
- HWDATA  in  32  write data, valid in the data phase
- HREADY  in  1  bus-level ready; qualifies the address phase
- HREADYOUT  out  1  slave ready
- HRDATA  out  32  read data
- HRESP  out  1  tied to 0 (OKAY)
- vid_req  in  1  video fetch request; held until granted
- vid_addr  in  ADDR_W  video word address
- vid_gnt  out  1  video access issued this cycle
- vid_rvalid  out  1  vid_rdata valid
- vid_rdata  out  32  video read data
- ram_en  out  1  RAM access strobe
- ram_we  out  4  byte write enables
- ram_addr  out  ADDR_W  RAM word address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid one cycle after ram_en

## Operation
- Address-phase capture: HSEL & HTRANS[1] & HREADY in state IDLE or DONE. Captures word address, HWRITE, HSIZE and HADDR[1:0].
- FSM states:
  - IDLE: no transfer pending.
  - WR: write waiting for the port.
  - RD: read waiting for the port.
  - RDATA: RAM output cycle.
  - DONE: transfer complete.
- Transitions:
  - IDLE/DONE → WR (capture, write), RD (capture, read), or IDLE (no capture).
  - WR → DONE in the cycle the write is issued.
  - RD → RDATA in the cycle the read is issued.
  - RDATA → DONE. HRDATA ← ram_rdata is registered on this transition.
- HREADYOUT = 1 in IDLE and DONE only. It is decoded from the state register.
- Port arbitration each cycle:
  - If vid_req, the video access goes out: ram_en=1, ram_we=0, ram_addr=vid_addr, vid_gnt=1.
  - Otherwise, if in WR or RD, the CPU access goes out.
  - vid_gnt is combinational.
- Write byte lanes are little-endian:
  - byte: ram_we = 1<<HADDR[1:0]
  - half: ram_we = 4'b0011 or 4'b1100, selected by HADDR[1]
  - word: ram_we = 4'b1111
  - ram_wdata = HWDATA, passed straight through.
- Unaligned and HSIZE>2 transfers are not checked. HSIZE>2 is treated as a word.
- vid_rvalid is registered from vid_gnt, asserted one cycle later. vid_rdata = ram_rdata.
- A CPU transfer is never lost. WR and RD persist until issued.

## Timing
- Write with the port free: address phase T0, write issued T1, HREADYOUT=1 at T2. One wait state.
- Read with the port free: address T0, issue T1, capture T2, HREADYOUT=1 with HRDATA at T3. Two wait states.
- Each cycle the port is taken by video adds one wait state.
- Back-to-back transfers: a new address phase is accepted in DONE. No idle cycle is required.
- HSEL low or HTRANS IDLE in DONE → IDLE.
- Reset, asserted at any time, including mid-transfer:
  - state = IDLE
  - HREADYOUT = 1, HRDATA = 0, HRESP = 0
  - vid_gnt = 0, vid_rvalid = 0
  - ram_en = 0, ram_we = 0
  - starvation counter = 0
  - Any in-flight access is abandoned.

## Configuration
- VRAM_ARB_STARVE_EN defined:
  - A counter increments on each cycle in WR or RD where video takes the port.
  - When the counter reaches MAX_WAIT, the CPU wins the next contended cycle and vid_gnt=0 in that cycle.
  - The counter clears on each CPU issue.
- Undefined: strict video priority. CPU latency is unbounded while vid_req is held high.

## Test plan
- Word write 0xDEADBEEF to HADDR 0x10, no video → ram_we=4'b1111, ram_addr=4 at T1; HREADYOUT high at T2.
- Byte write 0xAA to HADDR 0x13 → ram_we=4'b1000, ram_addr=4. Read back HADDR 0x10 → HRDATA=0xAAADBEEF at T3.
- Read while vid_req is held for 3 cycles → video granted 3 cycles, CPU read issued on the 4th cycle, HREADYOUT high 2 cycles later. vid_rvalid follows each vid_gnt by 1 cycle.
- With VRAM_ARB_STARVE_EN, MAX_WAIT=4, and vid_req held continuously → CPU issued on the 5th contended cycle with vid_gnt=0 that cycle. Without the macro → HREADYOUT stays 0 until vid_req drops.
- Pipelined write then read on consecutive address phases → both complete, read returns the new data, and no transfer is dropped.
- Assert SI_Reset while in RD → all outputs at reset values immediately. After release, a fresh read completes normally.
